oai22_vector_sequencer: RTL
===========================

# oai22_vector_sequencer

Synthesizable sequencer that exhaustively exercises one OAI22-style 4-input cell (ZN = ~((A1|A2)&(B1|B2))). It applies all 16 input vectors, waits a programmable settle time, samples ZN and compares it against the expected value. It accumulates a mismatch count and reports pass/fail with a start/done handshake. It sits between a test controller and one cell instance, and replaces free-running delay-based benches with a cycle-accurate clocked checker.

## Interface
- SETTLE_CYCLES, 2, wait cycles between driving a vector and sampling ZN; legal range 1..255.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin run; sampled only in IDLE
- zn  in  1  cell output under test
- a1, a2, b1, b2  out  1 each  registered cell inputs
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse at end of run
- pass  out  1  high when the last run completed with zero mismatches
- err_count  out  5  mismatches in the current or last run; range 0..16
- fail_vec  out  4  vector index {a1,a2,b1,b2} of the most recent mismatch
- vec_idx  out  4  index of the vector currently driven

## Operation
- States:
  - IDLE: start=1 moves to APPLY; clears err_count, fail_vec, pass and vec_idx.
  - APPLY: loads {a1,a2,b1,b2} <= vec_idx.
  - SETTLE: counts SETTLE_CYCLES cycles.
  - SAMPLE: compares zn against the expected value.
  - DONE: drives done=1 for one cycle, then returns to IDLE.
- Vector order is ascending 0000..1111, with bit 3 = a1 and bit 0 = b2.
- Expected value: ~((a1|a2)&(b1|b2)), computed from the registered drives.
- Compare uses case inequality, so X or Z on zn counts as a mismatch.
- On mismatch: err_count increments and fail_vec <= vec_idx.
- After SAMPLE: if vec_idx==15, go to DONE; otherwise increment vec_idx and go to APPLY.
- err_count cannot exceed 16; no wrap logic is needed, but the 5-bit width is mandatory.
- pass is set in DONE when err_count==0, and holds until the next accepted start or rst.
- start while busy (any state other than IDLE) is ignored; it is not queued.
- start held high continuously: a new run begins on the first IDLE cycle after DONE.

## Timing
- Reset values:
  - state = IDLE
  - a1, a2, b1, b2 = 0
  - busy = 0, done = 0, pass = 0
  - err_count = 0, fail_vec = 0, vec_idx = 0
- rst mid-run: on the next edge, all outputs take their reset values. No done pulse is produced, and the partial err_count is discarded.
- Each vector takes SETTLE_CYCLES+2 cycles: 1 APPLY, SETTLE_CYCLES SETTLE, 1 SAMPLE.
- done is asserted 16*(SETTLE_CYCLES+2)+1 cycles after the edge that samples start (65 at default).
- zn is sampled in the SAMPLE cycle; the cell has at least SETTLE_CYCLES full cycles after the drives change.
- The drives hold their last vector (1111) after DONE until the next APPLY or rst.

## Configuration
- OAI22_SEQ_STOP_ON_ERR_EN defined: the first mismatch ends the run.
  - SAMPLE goes directly to DONE, with err_count=1 and fail_vec = the failing index.
  - done arrives (k+1)*(SETTLE_CYCLES+2)+1 cycles after start, where k is the failing index.
- OAI22_SEQ_STOP_ON_ERR_EN undefined: all 16 vectors always run, and fail_vec holds the last failing index.

## Test plan
- Correct behavioural OAI22, SETTLE_CYCLES=2, start pulse -> busy=1 for the run, done exactly 65 cycles later, pass=1, err_count=0.
- Inverting cell model (ZN = (A1|A2)&(B1|B2)) -> err_count=16, fail_vec=15, pass=0.
- Model wrong only at vector 0101 (returns 1, expected 0) -> err_count=1, fail_vec=5, pass=0; with OAI22_SEQ_STOP_ON_ERR_EN, done arrives 25 cycles after start.
- start re-pulsed at cycle 10 of a run -> ignored, and done still arrives at cycle 65.
- rst asserted at cycle 30 -> the next edge gives busy=0, drives=0, err_count=0, with no done pulse; a following start completes a full 65-cycle run.
- SETTLE_CYCLES=1 with a correct model -> done 49 cycles after start, pass=1.

Source files
------------

// File: rtl/oai22_vector_sequencer.sv
// Clocked exhaustive checker for one OAI22 cell: drives all 16 input vectors,
// waits SETTLE_CYCLES, samples zn and counts mismatches. Optional build macro:
// OAI22_SEQ_STOP_ON_ERR_EN ends a run at the first mismatch.
module oai22_vector_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       zn,
  output logic       a1,
  output logic       a2,
  output logic       b1,
  output logic       b2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] fail_vec,
  output logic [3:0] vec_idx
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

`ifdef OAI22_SEQ_STOP_ON_ERR_EN
  localparam bit StopOnErr = 1'b1;
`else
  localparam bit StopOnErr = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [7:0] settle_cnt;
  logic       expected;
  logic       mismatch;
  logic       last_vec;
  logic       settle_last;

  // Expected value comes from the registered drives, not from vec_idx.
  assign expected    = ~((a1 | a2) & (b1 | b2));
  // Case inequality so an X or Z on zn is reported as a mismatch.
  assign mismatch    = (zn !== expected);
  assign last_vec    = (vec_idx == 4'd15);
  assign settle_last = (settle_cnt == 8'(SETTLE_CYCLES - 1));
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   state_d = SETTLE;
      SETTLE:  if (settle_last) state_d = SAMPLE;
      SAMPLE:  state_d = (last_vec || (StopOnErr && mismatch)) ? DONE : APPLY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {a1, a2, b1, b2} <= 4'd0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= 5'd0;
      fail_vec         <= 4'd0;
      vec_idx          <= 4'd0;
      settle_cnt       <= 8'd0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            err_count <= 5'd0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
            vec_idx   <= 4'd0;
          end
        end
        APPLY: begin
          {a1, a2, b1, b2} <= vec_idx;
          settle_cnt       <= 8'd0;
        end
        SETTLE: settle_cnt <= settle_cnt + 8'd1;
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 5'd1;
            fail_vec  <= vec_idx;
          end
          if (state_d == APPLY) vec_idx <= vec_idx + 4'd1;
        end
        DONE: begin
          done <= 1'b1;
          pass <= (err_count == 5'd0);
        end
        default: ;
      endcase
    end
  end

endmodule
